// File: rtl/ultrasonic_echo_emulator.sv
`timescale 1ns/1ps
// HC-SR04 responder: answers a valid trigger with a distance-encoded echo pulse.
// Optional TRIG_SYNC_EN: 2-flop synchroniser on trig (adds 2 cycles of latency).
module ultrasonic_echo_emulator #(
  parameter int unsigned TRIG_MIN_CYC = 500,
  parameter int unsigned BURST_CYC    = 10000,
  parameter int unsigned CYC_PER_CM   = 2900,
  parameter int unsigned TIMEOUT_CYC  = 1900000,
  parameter int unsigned HOLDOFF_CYC  = 500,
  parameter int unsigned DIST_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [DIST_W-1:0] dist_cm,
  input  logic              obj_present,
  output logic              echo,
  output logic              busy,
  output logic              short_trig
);

  localparam int unsigned MAX_DIST_CYC = ((1 << DIST_W) - 1) * CYC_PER_CM;
  localparam int unsigned MAX_W   = (TIMEOUT_CYC > MAX_DIST_CYC) ? TIMEOUT_CYC : MAX_DIST_CYC;
  localparam int unsigned MAX_A   = (MAX_W > BURST_CYC) ? MAX_W : BURST_CYC;
  localparam int unsigned MAX_B   = (MAX_A > HOLDOFF_CYC) ? MAX_A : HOLDOFF_CYC;
  localparam int unsigned MAX_ALL = (MAX_B > TRIG_MIN_CYC) ? MAX_B : TRIG_MIN_CYC;
  localparam int unsigned CW      = $clog2(MAX_ALL + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG_HI = 3'd1,
    BURST   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] width_q, width_d;
  logic          echo_q, echo_d;
  logic          busy_q, busy_d;
  logic          trig_s;
  logic          trig_q;

`ifdef TRIG_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], trig};
  end

  assign trig_s = sync_q[1];
`else
  assign trig_s = trig;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
      trig_q  <= trig_s;
    end
  end

  // Counters start at 1 on state entry so a compare against N spans exactly N cycles.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    width_d    = width_q;
    short_trig = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig_s && !trig_q) begin
          state_d = TRIG_HI;
          cnt_d   = CW'(1);
        end
      end
      TRIG_HI: begin
        if (trig_s) begin
          if (cnt_q < CW'(TRIG_MIN_CYC)) cnt_d = cnt_q + CW'(1);
        end else if (cnt_q >= CW'(TRIG_MIN_CYC)) begin
          state_d = BURST;
          cnt_d   = CW'(1);
          if (!obj_present || (dist_cm == '0)) width_d = CW'(TIMEOUT_CYC);
          else                                 width_d = CW'(dist_cm) * CW'(CYC_PER_CM);
        end else begin
          short_trig = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end
      end
      BURST: begin
        if (cnt_q == CW'(BURST_CYC - 1)) begin
          state_d = ECHO;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ECHO: begin
        if (cnt_q == width_q) begin
          state_d = HOLDOFF;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == CW'(HOLDOFF_CYC)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    echo_d = (state_d == ECHO);
    busy_d = (state_d == BURST) || (state_d == ECHO) || (state_d == HOLDOFF);
  end

  assign echo = echo_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
`timescale 1ns/1ps
// Randomised and directed bench for ultrasonic_echo_emulator against a timing-rule model.
module tb_ultrasonic_echo_emulator;

  localparam int TRIG_MIN = 10;
  localparam int BURST    = 20;
  localparam int CPC      = 5;
  localparam int TIMEOUT  = 2000;
  localparam int HOLDOFF  = 8;
`ifdef TRIG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic [7:0] dist_cm;
  logic       obj_present;
  logic       echo;
  logic       busy;
  logic       short_trig;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ultrasonic_echo_emulator #(
    .TRIG_MIN_CYC(TRIG_MIN),
    .BURST_CYC   (BURST),
    .CYC_PER_CM  (CPC),
    .TIMEOUT_CYC (TIMEOUT),
    .HOLDOFF_CYC (HOLDOFF),
    .DIST_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .dist_cm    (dist_cm),
    .obj_present(obj_present),
    .echo       (echo),
    .busy       (busy),
    .short_trig (short_trig)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Drives one trigger pulse of hi_len cycles (F = first low cycle) and checks the
  // observed response against the timing rules. Optional dist change after F and
  // optional extra trig pulse (offset from F), possibly held high to the end.
  task automatic run_txn(input string tag, input int hi_len, input logic [7:0] d0,
                         input logic obj, input int chg_at, input logic [7:0] d1,
                         input int x_start, input int x_len, input bit x_hold);
    int  f, exp_w, window, rel;
    int  rise, e_cnt, e_last, b_first, b_last, b_cnt, s_cnt, s_at;
    bit  valid;
    @(negedge clk);
    trig = 1'b0; dist_cm = d0; obj_present = obj;
    repeat (3) @(posedge clk);
    f      = hi_len;
    valid  = (hi_len >= TRIG_MIN);
    exp_w  = (!obj || d0 == 8'd0) ? TIMEOUT : int'(d0) * CPC;
    window = f + LAT + BURST + (valid ? exp_w : 0) + HOLDOFF + 15;
    rise = -1; e_cnt = 0; e_last = -1; b_first = -1; b_last = -1; b_cnt = 0; s_cnt = 0; s_at = -1;
    for (int k = 0; k < window; k++) begin
      @(posedge clk); #1;
      trig = (k < hi_len) ||
             (x_start >= 0 && k >= f + x_start && (x_hold || k < f + x_start + x_len));
      if (chg_at > 0 && k == f + chg_at) dist_cm = d1;
      @(negedge clk);
      rel = k - f;
      if (echo) begin
        if (rise < 0) rise = rel;
        e_cnt++; e_last = rel;
      end
      if (busy) begin
        if (b_first < 0) b_first = rel;
        b_cnt++; b_last = rel;
      end
      if (short_trig) begin
        if (s_at < 0) s_at = rel;
        s_cnt++;
      end
    end
    if (valid) begin
      check_eq($sformatf("%s_rise", tag), rise, LAT + BURST);
      check_eq($sformatf("%s_width", tag), e_cnt, exp_w);
      check_eq($sformatf("%s_echo_last", tag), e_last, LAT + BURST + exp_w - 1);
      check_eq($sformatf("%s_busy_first", tag), b_first, LAT + 1);
      check_eq($sformatf("%s_busy_last", tag), b_last, LAT + BURST + exp_w - 1 + HOLDOFF);
      check_eq($sformatf("%s_busy_cnt", tag), b_cnt, BURST - 1 + exp_w + HOLDOFF);
      check_eq($sformatf("%s_short_cnt", tag), s_cnt, 0);
    end else begin
      check_eq($sformatf("%s_echo_cnt", tag), e_cnt, 0);
      check_eq($sformatf("%s_busy_cnt", tag), b_cnt, 0);
      check_eq($sformatf("%s_short_cnt", tag), s_cnt, 1);
      check_eq($sformatf("%s_short_at", tag), s_at, LAT);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hl, xs, xl, ca, seen, e_after;
    logic [7:0] d, d1;
    logic ob;

    rst = 1'b1; trig = 1'b0; dist_cm = 8'd0; obj_present = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_echo", int'(echo), 0);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_short", int'(short_trig), 0);
    rst = 1'b0;

    run_txn("basic", 12, 8'd7, 1'b1, -1, 8'd0, -1, 0, 1'b0);
    run_txn("short", 6, 8'd7, 1'b1, -1, 8'd0, -1, 0, 1'b0);
    run_txn("after_short", 12, 8'd7, 1'b1, -1, 8'd0, -1, 0, 1'b0);
    run_txn("no_obj", 12, 8'd7, 1'b0, -1, 8'd0, -1, 0, 1'b0);
    run_txn("dist0", 12, 8'd0, 1'b1, -1, 8'd0, -1, 0, 1'b0);
    run_txn("min_len", TRIG_MIN, 8'd4, 1'b1, -1, 8'd0, -1, 0, 1'b0);
    run_txn("below_min", TRIG_MIN - 1, 8'd4, 1'b1, -1, 8'd0, -1, 0, 1'b0);
    run_txn("d255_chg", 12, 8'd255, 1'b1, 5, 8'd3, -1, 0, 1'b0);
    run_txn("d3_next", 12, 8'd3, 1'b1, -1, 8'd0, -1, 0, 1'b0);
    run_txn("retrig_echo", 12, 8'd7, 1'b1, -1, 8'd0, BURST + 3, 5, 1'b0);
    run_txn("hold_idle", 12, 8'd7, 1'b1, -1, 8'd0, BURST + 35 - 3, 0, 1'b1);
    run_txn("after_hold", 12, 8'd7, 1'b1, -1, 8'd0, -1, 0, 1'b0);

    // Reset in the middle of an echo pulse
    @(negedge clk); trig = 1'b0; dist_cm = 8'd7; obj_present = 1'b1;
    repeat (3) @(posedge clk);
    for (int k = 0; k < 12; k++) begin @(posedge clk); #1; trig = 1'b1; end
    @(posedge clk); #1; trig = 1'b0;
    seen = 0;
    for (int k = 0; k < 200 && seen == 0; k++) begin
      @(negedge clk);
      if (echo) seen = 1;
    end
    check_eq("rst_echo_seen", seen, 1);
    repeat (10) @(negedge clk);
    #2; rst = 1'b1; #1;
    check_eq("rst_echo_async", int'(echo), 0);
    check_eq("rst_busy_async", int'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    e_after = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (echo || busy) e_after++;
    end
    check_eq("rst_no_resume", e_after, 0);
    run_txn("after_rst", 12, 8'd7, 1'b1, -1, 8'd0, -1, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      hl = $urandom_range(16, 4);
      d  = 8'($urandom_range(30, 0));
      ob = ($urandom_range(5, 0) != 0);
      ca = -1; d1 = 8'($urandom_range(255, 0));
      if ($urandom_range(1, 0) == 1) ca = $urandom_range(5, 1);
      xs = -1; xl = 0;
      if (hl >= TRIG_MIN && $urandom_range(2, 0) == 0) begin
        xs = $urandom_range(BURST, 2);
        xl = $urandom_range(4, 1);
      end
      run_txn($sformatf("rnd%0d", i), hl, d, ob, ca, d1, xs, xl, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
